petersen_draw_seq: RTL



---
 rtl/petersen_pkg.sv | 88 ++++++++
 rtl/petersen_edge_rom.sv | 23 ++
 rtl/petersen_draw_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/petersen_pkg.sv
// Shared definitions for the Petersen graph drawer: coordinate widths, the
// vertex/edge tables as lookup functions, and the sequencer state encoding.
package petersen_pkg;

  localparam int COORD_W   = 9;
  localparam int VID_W     = 4;
  localparam int EDGE_W    = 4;
  localparam int NUM_EDGES = 15;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(NUM_EDGES - 1);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [VID_W-1:0]   vid_t;

  typedef struct packed {
    vid_t va;
    vid_t vb;
  } edge_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  // Outer pentagon v0-v4, inner pentagram v5-v9, in panel pixels.
  function automatic coord_t vertex_x(input vid_t v);
    coord_t x;
    case (v)
      4'd0:    x = 9'd120;
      4'd1:    x = 9'd215;
      4'd2:    x = 9'd179;
      4'd3:    x = 9'd61;
      4'd4:    x = 9'd25;
      4'd5:    x = 9'd120;
      4'd6:    x = 9'd168;
      4'd7:    x = 9'd149;
      4'd8:    x = 9'd91;
      4'd9:    x = 9'd72;
      default: x = 9'd0;
    endcase
    return x;
  endfunction

  function automatic coord_t vertex_y(input vid_t v);
    coord_t y;
    case (v)
      4'd0:    y = 9'd60;
      4'd1:    y = 9'd129;
      4'd2:    y = 9'd241;
      4'd3:    y = 9'd241;
      4'd4:    y = 9'd129;
      4'd5:    y = 9'd110;
      4'd6:    y = 9'd145;
      4'd7:    y = 9'd200;
      4'd8:    y = 9'd200;
      4'd9:    y = 9'd145;
      default: y = 9'd0;
    endcase
    return y;
  endfunction

  function automatic edge_t edge_ends(input logic [EDGE_W-1:0] idx);
    edge_t e;
    case (idx)
      4'd0:    e = {4'd0, 4'd1};
      4'd1:    e = {4'd1, 4'd2};
      4'd2:    e = {4'd2, 4'd3};
      4'd3:    e = {4'd3, 4'd4};
      4'd4:    e = {4'd4, 4'd0};
      4'd5:    e = {4'd0, 4'd5};
      4'd6:    e = {4'd1, 4'd6};
      4'd7:    e = {4'd2, 4'd7};
      4'd8:    e = {4'd3, 4'd8};
      4'd9:    e = {4'd4, 4'd9};
      4'd10:   e = {4'd5, 4'd7};
      4'd11:   e = {4'd6, 4'd8};
      4'd12:   e = {4'd7, 4'd9};
      4'd13:   e = {4'd8, 4'd5};
      4'd14:   e = {4'd9, 4'd6};
      default: e = {4'd0, 4'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/petersen_edge_rom.sv
// Combinational edge lookup: edge index -> endpoint coordinates of that edge.
module petersen_edge_rom
  import petersen_pkg::*;
(
  input  logic [EDGE_W-1:0] edge_idx,
  output coord_t            x1,
  output coord_t            y1,
  output coord_t            x2,
  output coord_t            y2
);

  edge_t ends_s;

  // Resolve the edge to its two vertex ids, then to panel coordinates.
  always_comb begin
    ends_s = edge_ends(edge_idx);
    x1     = vertex_x(ends_s.va);
    y1     = vertex_y(ends_s.va);
    x2     = vertex_x(ends_s.vb);
    y2     = vertex_y(ends_s.vb);
  end

endmodule

// File: rtl/petersen_draw_seq.sv
// Petersen graph draw sequencer: hands the 15 edges to the SPI line engine one
// at a time over a start/done handshake, with an optional gap and timeout.
module petersen_draw_seq
  import petersen_pkg::*;
#(
  parameter int          GAP_CYCLES     = 20,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_line_done,
  output logic               o_line_start,
  output logic [COORD_W-1:0] o_x1,
  output logic [COORD_W-1:0] o_y1,
  output logic [COORD_W-1:0] o_x2,
  output logic [COORD_W-1:0] o_y2,
  output logic [EDGE_W-1:0]  o_edge_idx,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam bit GAP_EN = (GAP_CYCLES > 0);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 24'd0);
  localparam logic [23:0] TO_LAST = TIMEOUT_CYCLES - 24'd1;

  state_e            state_r, state_s;
  logic [EDGE_W-1:0] edge_idx_r, edge_idx_s;
  logic [GAP_W-1:0]  gap_cnt_r, gap_cnt_s;
  logic [23:0]       to_cnt_r, to_cnt_s;
  coord_t            x1_r, y1_r, x2_r, y2_r;
  coord_t            x1_s, y1_s, x2_s, y2_s;
  coord_t            rom_x1_s, rom_y1_s, rom_x2_s, rom_y2_s;
  logic              line_start_r, line_start_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              last_edge_s, gap_done_s, timeout_s;

  petersen_edge_rom u_rom (
    .edge_idx (edge_idx_r),
    .x1       (rom_x1_s),
    .y1       (rom_y1_s),
    .x2       (rom_x2_s),
    .y2       (rom_y2_s)
  );

  // Terminal-condition decodes shared by next-state and datapath logic.
  always_comb begin
    last_edge_s = (edge_idx_r == LAST_EDGE);
    gap_done_s  = (gap_cnt_r == GAP_LAST);
    timeout_s   = TO_EN && (to_cnt_r == TO_LAST);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a done in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) state_s = ST_LOAD;
        else         state_s = ST_IDLE;
      end
      ST_LOAD:  state_s = ST_START;
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (i_line_done) begin
          if (GAP_EN)           state_s = ST_GAP;
          else if (last_edge_s) state_s = ST_FIN;
          else                  state_s = ST_LOAD;
        end else if (timeout_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (!gap_done_s)      state_s = ST_GAP;
        else if (last_edge_s) state_s = ST_FIN;
        else                  state_s = ST_LOAD;
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values; flags are decoded from the next state so
  // the registered outputs line up with the state they describe.
  always_comb begin
    edge_idx_s   = edge_idx_r;
    gap_cnt_s    = {GAP_W{1'b0}};
    to_cnt_s     = 24'd0;
    x1_s         = x1_r;
    y1_s         = y1_r;
    x2_s         = x2_r;
    y2_s         = y2_r;
    err_s        = err_r;
    line_start_s = (state_s == ST_START);
    busy_s       = (state_s == ST_LOAD) || (state_s == ST_START) ||
                   (state_s == ST_WAIT) || (state_s == ST_GAP);
    done_s       = (state_s == ST_FIN);
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          edge_idx_s = 4'd0;
          err_s      = 1'b0;
        end else begin
          edge_idx_s = edge_idx_r;
        end
      end
      ST_LOAD: begin
        x1_s = rom_x1_s;
        y1_s = rom_y1_s;
        x2_s = rom_x2_s;
        y2_s = rom_y2_s;
      end
      ST_WAIT: begin
        to_cnt_s = to_cnt_r + 24'd1;
        if (!i_line_done && timeout_s) err_s = 1'b1;
        else                           err_s = err_r;
        if (state_s == ST_LOAD) edge_idx_s = edge_idx_r + 4'd1;
        else                    edge_idx_s = edge_idx_r;
      end
      ST_GAP: begin
        if (gap_done_s) gap_cnt_s = {GAP_W{1'b0}};
        else            gap_cnt_s = gap_cnt_r + GAP_ONE;
        if (state_s == ST_LOAD) edge_idx_s = edge_idx_r + 4'd1;
        else                    edge_idx_s = edge_idx_r;
      end
      default: begin
        edge_idx_s = edge_idx_r;
      end
    endcase
  end

  // Datapath and output registers; all clear asynchronously on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      edge_idx_r   <= 4'd0;
      gap_cnt_r    <= {GAP_W{1'b0}};
      to_cnt_r     <= 24'd0;
      x1_r         <= 9'd0;
      y1_r         <= 9'd0;
      x2_r         <= 9'd0;
      y2_r         <= 9'd0;
      line_start_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      edge_idx_r   <= edge_idx_s;
      gap_cnt_r    <= gap_cnt_s;
      to_cnt_r     <= to_cnt_s;
      x1_r         <= x1_s;
      y1_r         <= y1_s;
      x2_r         <= x2_s;
      y2_r         <= y2_s;
      line_start_r <= line_start_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      err_r        <= err_s;
    end
  end

  assign o_line_start = line_start_r;
  assign o_x1         = x1_r;
  assign o_y1         = y1_r;
  assign o_x2         = x2_r;
  assign o_y2         = y2_r;
  assign o_edge_idx   = edge_idx_r;
  assign o_busy       = busy_r;
  assign o_done       = done_r;
  assign o_err        = err_r;

endmodule
